regfile_dump_reader: RTL and testbench

- Debug-side reader for the processor register bank. On a START request it walks register addresses FIRST_REG..LAST_REG through a dedicated read-address/read-data port of the register file, taking R15 from the PC path instead.
- Each register value is streamed out as one tagged 32-bit word on a valid/ready interface, toward the UART/console dump logic.
- While a dump is running, the block asserts a stall request so the core freezes register writes, keeping the dump a consistent snapshot.

---
 rtl/regfile_dump_reader.sv | 99 +++++++++
 tb/tb_regfile_dump_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Debug register-bank dumper: walks FIRST_REG..LAST_REG through the debug read port
// (R15 comes from the PC path) and streams tagged words on a valid/ready interface.
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        ABORT,
    output logic [3:0]  A_DBG,
    input  logic [31:0] RD_DBG,
    input  logic [31:0] R15,
    output logic [31:0] DBG_DATA,
    output logic [3:0]  DBG_TAG,
    output logic        DBG_VALID,
    input  logic        DBG_READY,
    output logic        BUSY,
    output logic        STALL_REQ,
    output logic        DONE
);

    generate
        if (FIRST_REG > LAST_REG || LAST_REG > 15) begin : g_bad_range
            $error("regfile_dump_reader: register range out of order or above 15");
        end
    endgenerate

    localparam logic [3:0] FIRST_IDX = FIRST_REG[3:0];
    localparam logic [3:0] LAST_IDX  = LAST_REG[3:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_FIN
    } state_t;

    state_t     state;
    logic [3:0] idx;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            idx       <= FIRST_IDX;
            DBG_DATA  <= 32'd0;
            DBG_TAG   <= 4'd0;
            DBG_VALID <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            // Abort beats everything once a dump is under way, including the DONE pulse.
            if (ABORT && state != S_IDLE) begin
                state     <= S_IDLE;
                idx       <= FIRST_IDX;
                DBG_VALID <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            idx   <= FIRST_IDX;
                            state <= S_READ;
                        end
                    end
                    S_READ: begin
                        DBG_DATA  <= (idx == 4'd15) ? R15 : RD_DBG;
                        DBG_TAG   <= idx;
                        DBG_VALID <= 1'b1;
                        state     <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (DBG_READY) begin
                            DBG_VALID <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state <= S_FIN;
                            end else begin
                                idx   <= idx + 4'd1;
                                state <= S_READ;
                            end
                        end
                    end
                    S_FIN: begin
                        DONE  <= 1'b1;
                        idx   <= FIRST_IDX;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign A_DBG     = idx;
    assign BUSY      = (state == S_READ) || (state == S_HOLD);
    assign STALL_REQ = BUSY;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-range and sub-range instances sharing
// a small register-file harness whose writes are blocked while either dump stalls the core.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, abort0, ready0, start1, abort1, ready1;
    logic [3:0]  a0, a1, tag0, tag1;
    logic [31:0] rd0, rd1, data0, data1;
    logic [31:0] r15 = 32'h0000_0108;
    logic        valid0, busy0, stall0, done0;
    logic        valid1, busy1, stall1, done1;

    logic [31:0] rf [16];
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;

    int checks = 0;
    int errors = 0;

    int          nw;
    int          done_cyc;
    int          done_cnt;
    logic        busy_at0;
    logic        stall_at_wr;
    logic [3:0]  seq_tag  [64];
    logic [31:0] seq_data [64];

    always #5 clk = ~clk;

    assign rd0 = rf[a0];
    assign rd1 = rf[a1];
    always @(posedge clk) begin
        if (we && !(stall0 || stall1)) rf[wa] <= wd;
    end

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(15)) u0 (
        .CLK(clk), .RESET(rst), .START(start0), .ABORT(abort0),
        .A_DBG(a0), .RD_DBG(rd0), .R15(r15),
        .DBG_DATA(data0), .DBG_TAG(tag0), .DBG_VALID(valid0), .DBG_READY(ready0),
        .BUSY(busy0), .STALL_REQ(stall0), .DONE(done0)
    );

    regfile_dump_reader #(.FIRST_REG(4), .LAST_REG(6)) u1 (
        .CLK(clk), .RESET(rst), .START(start1), .ABORT(abort1),
        .A_DBG(a1), .RD_DBG(rd1), .R15(r15),
        .DBG_DATA(data1), .DBG_TAG(tag1), .DBG_VALID(valid1), .DBG_READY(ready1),
        .BUSY(busy1), .STALL_REQ(stall1), .DONE(done1)
    );

    function automatic logic [31:0] exp_val(input int r);
        return (r == 15) ? 32'h0000_0108 : (32'h1000_0000 + r);
    endfunction

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 4'(i); wd = 32'h1000_0000 + i;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    // Starts a dump on instance sel and records accepted words; n counts edges after START is sampled.
    task automatic run_dump(input int sel, input int wr_at);
        logic v, rdy, d;
        nw = 0; done_cyc = -1; done_cnt = 0; stall_at_wr = 1'b0;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        busy_at0 = (sel == 0) ? busy0 : busy1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == wr_at) begin
                we = 1'b1; wa = 4'd5; wd = 32'hDEAD_BEEF;
                stall_at_wr = stall0;
            end else begin
                we = 1'b0;
            end
            v   = (sel == 0) ? valid0 : valid1;
            rdy = (sel == 0) ? ready0 : ready1;
            d   = (sel == 0) ? done0  : done1;
            if (v && rdy && nw < 64) begin
                seq_tag[nw]  = (sel == 0) ? tag0 : tag1;
                seq_data[nw] = (sel == 0) ? data0 : data1;
                nw++;
            end
            if (d) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc >= 0 && n >= done_cyc + 3) break;
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start0 = 0; abort0 = 0; ready0 = 0; start1 = 0; abort1 = 0; ready1 = 0;
        we = 0; wa = 0; wd = 0;
        repeat (3) @(negedge clk);
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid0); end
        checks++; if (busy0 !== 1'b0 || stall0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b/%0b want 0/0", busy0, stall0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done0); end
        checks++; if (data0 !== 32'd0 || tag0 !== 4'd0) begin errors++; $display("FAIL reset_data got %h/%0d want 0/0", data0, tag0); end
        checks++; if (a0 !== 4'd0) begin errors++; $display("FAIL reset_addr0 got %0d want 0", a0); end
        checks++; if (a1 !== 4'd4) begin errors++; $display("FAIL reset_addr1 got %0d want 4", a1); end
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        int bad;
        ready0 = 1'b1;
        run_dump(0, -1);
        checks++; if (busy_at0 !== 1'b1) begin errors++; $display("FAIL full_busy_rise got %0b want 1", busy_at0); end
        checks++; if (nw != 16) begin errors++; $display("FAIL full_count got %0d want 16", nw); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (k >= nw || seq_tag[k] !== 4'(k) || seq_data[k] !== exp_val(k)) begin
                errors++;
                $display("FAIL full_word%0d got tag %0d data %h want tag %0d data %h",
                         k, seq_tag[k], seq_data[k], k, exp_val(k));
            end
        end
        checks++; if (done_cyc != 33) begin errors++; $display("FAIL full_done_cycle got %0d want 33", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_width got %0d want 1", done_cnt); end
        bad = (busy0 !== 1'b0 || stall0 !== 1'b0 || a0 !== 4'd0) ? 1 : 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_after got busy %0b addr %0d want 0/0", busy0, a0); end
    endtask

    task automatic test_backpressure();
        int hold_cnt = 0;
        logic held = 1'b0;
        logic done_seen = 1'b0;
        int cnt3 = 0;
        nw = 0;
        ready0 = 1'b1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 80 && !done_seen; n++) begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                checks++;
                if (valid0 !== 1'b1 || data0 !== 32'h1000_0003 || tag0 !== 4'd3) begin
                    errors++;
                    $display("FAIL bp_hold got v %0b data %h tag %0d want 1 10000003 3", valid0, data0, tag0);
                end
                hold_cnt--;
                if (hold_cnt == 0) ready0 = 1'b1;
            end else if (valid0 && tag0 == 4'd3 && !held) begin
                ready0 = 1'b0; held = 1'b1; hold_cnt = 5;
            end
            if (valid0 && ready0 && nw < 64) begin
                seq_tag[nw] = tag0; nw++;
                if (tag0 == 4'd3) cnt3++;
            end
            if (done0) done_seen = 1'b1;
        end
        ready0 = 1'b1;
        checks++; if (cnt3 != 1) begin errors++; $display("FAIL bp_accept_once got %0d want 1", cnt3); end
        checks++; if (nw != 16 || seq_tag[4] !== 4'd4) begin errors++; $display("FAIL bp_sequence got %0d words next %0d want 16 words next 4", nw, seq_tag[4]); end
    endtask

    task automatic test_subrange();
        ready1 = 1'b1;
        run_dump(1, -1);
        checks++; if (nw != 3) begin errors++; $display("FAIL sub_count got %0d want 3", nw); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seq_tag[k] !== 4'(k + 4) || seq_data[k] !== exp_val(k + 4)) begin
                errors++;
                $display("FAIL sub_word%0d got tag %0d data %h want tag %0d data %h",
                         k, seq_tag[k], seq_data[k], k + 4, exp_val(k + 4));
            end
        end
        checks++; if (done_cnt != 1 || done_cyc != 7) begin errors++; $display("FAIL sub_done got %0d pulses at %0d want 1 at 7", done_cnt, done_cyc); end
        checks++; if (a1 !== 4'd4) begin errors++; $display("FAIL sub_addr_idle got %0d want 4", a1); end
    endtask

    task automatic test_abort();
        logic found = 1'b0;
        int dcount = 0;
        ready0 = 1'b1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 60 && !found; n++) begin
            @(negedge clk);
            if (valid0 && tag0 == 4'd7) begin
                found = 1'b1; ready0 = 1'b0; abort0 = 1'b1;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_r7 got 0 want 1"); end
        @(negedge clk);
        abort0 = 1'b0;
        checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0 || stall0 !== 1'b0) begin errors++; $display("FAIL abort_idle got v %0b busy %0b want 0/0", valid0, busy0); end
        checks++; if (a0 !== 4'd0) begin errors++; $display("FAIL abort_addr got %0d want 0", a0); end
        for (int n = 0; n < 5; n++) begin
            if (done0) dcount++;
            @(negedge clk);
        end
        checks++; if (dcount != 0 || done0 !== 1'b0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dcount); end
        ready0 = 1'b1;
        run_dump(0, -1);
        checks++; if (nw != 16 || seq_tag[0] !== 4'd0 || seq_data[0] !== 32'h1000_0000) begin
            errors++; $display("FAIL abort_restart got %0d words first tag %0d want 16 words first tag 0", nw, seq_tag[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        int bad = 0;
        nw = 0;
        ready0 = 1'b1;
        @(negedge clk); start0 = 1'b1;
        for (int n = 0; n <= 60 && !found; n++) begin
            @(negedge clk);
            start0 = (n % 3 == 0) ? 1'b1 : 1'b0;
            if (valid0 && tag0 == 4'd9) begin
                found = 1'b1;
            end else if (valid0 && ready0 && nw < 64) begin
                seq_tag[nw] = tag0; nw++;
            end
        end
        start0 = 1'b0;
        for (int k = 0; k < nw; k++) if (seq_tag[k] !== 4'(k)) bad++;
        checks++; if (!found || nw != 9 || bad != 0) begin errors++; $display("FAIL rmid_sequence got %0d words %0d out of order want 9 words 0", nw, bad); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (valid0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0 || stall0 !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl got v %0b d %0b b %0b want 0", valid0, done0, busy0);
        end
        checks++; if (data0 !== 32'd0 || tag0 !== 4'd0 || a0 !== 4'd0) begin
            errors++; $display("FAIL rmid_data got %h tag %0d addr %0d want 0/0/0", data0, tag0, a0);
        end
    endtask

    task automatic test_stall_write();
        ready0 = 1'b1;
        run_dump(0, 2);
        checks++; if (stall_at_wr !== 1'b1) begin errors++; $display("FAIL stall_during_write got %0b want 1", stall_at_wr); end
        checks++; if (nw != 16 || seq_data[5] !== 32'h1000_0005) begin errors++; $display("FAIL stall_dumped_r5 got %h want 10000005", seq_data[5]); end
        checks++; if (rf[5] !== 32'h1000_0005) begin errors++; $display("FAIL stall_rf_r5 got %h want 10000005", rf[5]); end
    endtask

    initial begin
        test_reset();
        preload();
        test_full_dump();
        test_backpressure();
        test_subrange();
        test_abort();
        test_reset_mid();
        test_stall_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
